// File: rtl/dcache_axi_bridge.sv
// ---------------------------------------------------------------------------
// dcache_axi_bridge
//
// Converts single-beat data-cache requests into AXI read or write
// transactions. Exactly one transaction is outstanding at a time: a request
// is latched in IDLE, it is played out on the AXI channels, and the bridge
// returns to IDLE after a one-cycle m_ready completion pulse.
//
// Ports
//   clk, rst      : clock; synchronous active-high reset
//   m_strobe      : cache request, sampled only in IDLE
//   m_rw          : 0 = read, 1 = write
//   m_a           : byte address
//   m_din, m_wen  : write data and byte enables
//   m_size        : 0 byte, 1 half, 2 word
//   m_dout        : last captured read word (register)
//   m_ready       : one-cycle completion pulse
//   ar*/r*        : AXI read address and read data channels
//   aw*/w*/b*     : AXI write address, write data and write response channels
//
// All AXI-facing address, data, strobe and size outputs are driven from the
// latched request registers, and all valid/ready outputs are decoded from
// registered state, so no output depends combinationally on any input.
// ---------------------------------------------------------------------------
module dcache_axi_bridge #(
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,

    // Cache side
    input  logic               m_strobe,
    input  logic               m_rw,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    input  logic [3:0]         m_wen,
    input  logic [1:0]         m_size,
    output logic [31:0]        m_dout,
    output logic               m_ready,

    // AXI read address / data
    output logic [A_WIDTH-1:0] araddr,
    output logic [2:0]         arsize,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic               rvalid,
    output logic               rready,

    // AXI write address / data / response
    output logic [A_WIDTH-1:0] awaddr,
    output logic [2:0]         awsize,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic               bvalid,
    output logic               bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request
    logic [A_WIDTH-1:0] req_addr;
    logic [31:0]        req_din;
    logic [3:0]         req_wen;
    logic [1:0]         req_size;
    logic               req_rw;

    // Per-channel "handshake already happened" flags for the write request
    // phase; AW and W complete independently and in any order.
    logic aw_done;
    logic w_done;

    logic [31:0] dout_q;

    logic accept;
    logic aw_fire;
    logic w_fire;
    logic aw_complete;
    logic w_complete;

    // A request is taken only in IDLE; strobes in any other state are ignored.
    assign accept = (state == IDLE) && m_strobe;

    // Output decode from registered state only.
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);
    assign awvalid = (state == WR_REQ) && !aw_done;
    assign wvalid  = (state == WR_REQ) && !w_done;
    assign bready  = (state == WR_RESP);
    assign m_ready = (state == DONE);

    assign araddr  = req_addr;
    assign awaddr  = req_addr;
    assign arsize  = {1'b0, req_size};
    assign awsize  = {1'b0, req_size};
    assign wdata   = req_din;
    assign wstrb   = req_wen;
    assign m_dout  = dout_q;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    // A channel counts as complete if it finished earlier or finishes now.
    assign aw_complete = aw_done || aw_fire;
    assign w_complete  = w_done || w_fire;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m_strobe) begin
                    state_next = m_rw ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    state_next = DONE;
                end
            end
            WR_REQ: begin
                if (aw_complete && w_complete) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                // Response code is deliberately ignored; any bvalid completes.
                if (bvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture. The write handshake flags are cleared on every new
    // request so a previous write's completion never leaks into the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr <= '0;
            req_din  <= '0;
            req_wen  <= '0;
            req_size <= '0;
            req_rw   <= 1'b0;
        end else if (accept) begin
            req_addr <= m_a;
            req_din  <= m_din;
            req_wen  <= m_wen;
            req_size <= m_size;
            req_rw   <= m_rw;
        end
    end

    // Write channel handshake tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                w_done <= 1'b1;
            end
        end
    end

    // Read data capture; m_dout holds its value across writes and idle time.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if ((state == RD_DATA) && rvalid && !req_rw) begin
            dout_q <= rdata;
        end
    end

endmodule
